pe_rx_sink: RTL

PE_RX_SINK -- requirements
Module: pe_rx_sink

---
 rtl/pe_flit_pkg.sv | 64 ++++++
 rtl/pe_rx_vc_fifo.sv | 80 ++++++++
 rtl/pe_rx_sink.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pe_flit_pkg.sv
// Shared flit/credit layout for the PE endpoints.
// Default sizing comes from the NUM_VCS, FLIT_BUFFER_DEPTH, FLIT_DATA_WIDTH
// and NUM_USER_RECV_PORTS macros when they are not set by the build.
// Flit layout, MSB first: {valid, tail, dest, vc, data}. Credit layout: {valid, vc}.

`ifndef NUM_VCS
`define NUM_VCS 2
`endif
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 64
`endif
`ifndef NUM_USER_RECV_PORTS
`define NUM_USER_RECV_PORTS 4
`endif

package pe_flit_pkg;

  // A single VC still needs a one-bit vc field so the flit format stays uniform.
  function automatic int calc_vc_bits(input int num_vcs);
    return (num_vcs > 1) ? $clog2(num_vcs) : 1;
  endfunction

  // A single-port network keeps a one-bit dest field so the port never collapses to zero width.
  function automatic int calc_dest_bits(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  function automatic int calc_flit_w(input int data_w, input int num_vcs, input int num_ports);
    return 2 + data_w + calc_dest_bits(num_ports) + calc_vc_bits(num_vcs);
  endfunction

  function automatic int calc_credit_w(input int num_vcs);
    return 1 + calc_vc_bits(num_vcs);
  endfunction

  // Field offsets, counted from bit 0 of the flit.
  localparam int FLIT_DATA_LSB = 0;

  function automatic int calc_vc_lsb(input int data_w);
    return FLIT_DATA_LSB + data_w;
  endfunction

  function automatic int calc_dest_lsb(input int data_w, input int num_vcs);
    return calc_vc_lsb(data_w) + calc_vc_bits(num_vcs);
  endfunction

  function automatic int calc_tail_bit(input int data_w, input int num_vcs, input int num_ports);
    return calc_dest_lsb(data_w, num_vcs) + calc_dest_bits(num_ports);
  endfunction

  function automatic int calc_valid_bit(input int data_w, input int num_vcs, input int num_ports);
    return calc_tail_bit(data_w, num_vcs, num_ports) + 1;
  endfunction

  // Default-configuration widths for PE modules that do not override the sizing.
  localparam int DEFAULT_VC_BITS   = calc_vc_bits(`NUM_VCS);
  localparam int DEFAULT_DEST_BITS = calc_dest_bits(`NUM_USER_RECV_PORTS);
  localparam int DEFAULT_FLIT_W    = calc_flit_w(`FLIT_DATA_WIDTH, `NUM_VCS, `NUM_USER_RECV_PORTS);
  localparam int DEFAULT_CREDIT_W  = calc_credit_w(`NUM_VCS);

endpackage

// File: rtl/pe_rx_vc_fifo.sv
// One per-VC flit buffer for pe_rx_sink: DEPTH entries of {tail, data}.
// Writes are refused when the buffer is full at the start of the cycle, even if
// a pop happens in the same cycle. Read data is the registered head entry, so a
// newly written flit becomes visible only after the write edge.

module pe_rx_vc_fifo
  import pe_flit_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 65,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               empty,
  output logic               full
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_write;
  logic               do_read;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // Next pointer and occupancy; a simultaneous write and read leaves occupancy unchanged.
  always_comb begin
    do_write = wr_en && !full;
    do_read  = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_write) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (do_read) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_write, do_read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy governs validity.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/pe_rx_sink.sv
// Receive-side sink of a PE endpoint: buffers incoming flits per VC, presents one
// buffered flit at a time to the consumer using round-robin over the VCs, and
// returns one credit per consumed flit to the sender.
// Optional protocol checking (overflow, wrong destination) is built only when
// PE_RX_ERR_CHECK_EN is defined; otherwise err is tied low.

`ifndef NUM_VCS
`define NUM_VCS 2
`endif
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 64
`endif
`ifndef NUM_USER_RECV_PORTS
`define NUM_USER_RECV_PORTS 4
`endif

module pe_rx_sink
  import pe_flit_pkg::*;
#(
  parameter int NUM_VCS    = `NUM_VCS,
  parameter int DEPTH      = `FLIT_BUFFER_DEPTH,
  parameter int DATA_W     = `FLIT_DATA_WIDTH,
  parameter int NUM_PORTS  = `NUM_USER_RECV_PORTS,
  localparam int VC_BITS   = calc_vc_bits(NUM_VCS),
  localparam int DEST_BITS = calc_dest_bits(NUM_PORTS),
  localparam int FLIT_W    = calc_flit_w(DATA_W, NUM_VCS, NUM_PORTS),
  localparam int CREDIT_W  = calc_credit_w(NUM_VCS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [FLIT_W-1:0]    flit_in,
  output logic                 en_receiveFlit,
  output logic [CREDIT_W-1:0]  credit_out,
  output logic                 sendCredit,
  input  logic [DEST_BITS-1:0] recvPortID,
  output logic                 deq_valid,
  input  logic                 deq_ready,
  output logic [DATA_W-1:0]    deq_data,
  output logic [VC_BITS-1:0]   deq_vc,
  output logic                 deq_tail,
  output logic                 err
);

  localparam int ENTRY_W   = DATA_W + 1;
  localparam int VC_LSB    = calc_vc_lsb(DATA_W);
  localparam int DEST_LSB  = calc_dest_lsb(DATA_W, NUM_VCS);
  localparam int TAIL_BIT  = calc_tail_bit(DATA_W, NUM_VCS, NUM_PORTS);
  localparam int VALID_BIT = calc_valid_bit(DATA_W, NUM_VCS, NUM_PORTS);

  // Decoded incoming flit
  logic                 flit_valid;
  logic                 flit_tail;
  logic [DEST_BITS-1:0] flit_dest;
  logic [VC_BITS-1:0]   flit_vc;
  logic [DATA_W-1:0]    flit_data;

  // Per-VC buffer interface
  logic [NUM_VCS-1:0]   wr_en_v;
  logic [NUM_VCS-1:0]   rd_en_v;
  logic [NUM_VCS-1:0]   empty_v;
  logic [NUM_VCS-1:0]   full_v;
  logic [ENTRY_W-1:0]   head [NUM_VCS];

  // Arbitration and credit state
  logic [VC_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [VC_BITS-1:0]   sel_vc;
  logic                 sel_found;
  int                   rr_idx;
  logic                 pop;
  logic                 credit_valid_q, credit_valid_d;
  logic [VC_BITS-1:0]   credit_vc_q, credit_vc_d;
  logic                 en_rx_q, en_rx_d;

  assign flit_valid = flit_in[VALID_BIT];
  assign flit_tail  = flit_in[TAIL_BIT];
  assign flit_dest  = flit_in[DEST_LSB +: DEST_BITS];
  assign flit_vc    = flit_in[VC_LSB +: VC_BITS];
  assign flit_data  = flit_in[FLIT_DATA_LSB +: DATA_W];

  for (genvar g = 0; g < NUM_VCS; g++) begin : g_vc
    assign wr_en_v[g] = en && flit_valid && (flit_vc == VC_BITS'(g));
    assign rd_en_v[g] = pop && (sel_vc == VC_BITS'(g));

    pe_rx_vc_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en_v[g]),
      .wr_data ({flit_tail, flit_data}),
      .rd_en   (rd_en_v[g]),
      .rd_data (head[g]),
      .empty   (empty_v[g]),
      .full    (full_v[g])
    );
  end

  // Round-robin pick: first nonempty VC scanning upward from rr_ptr, wrapping.
  always_comb begin
    sel_vc    = rr_ptr_q;
    sel_found = 1'b0;
    rr_idx    = 0;
    for (int i = 0; i < NUM_VCS; i++) begin
      rr_idx = int'(rr_ptr_q) + i;
      if (rr_idx >= NUM_VCS) begin
        rr_idx = rr_idx - NUM_VCS;
      end
      if (!sel_found && !empty_v[VC_BITS'(rr_idx)]) begin
        sel_found = 1'b1;
        sel_vc    = VC_BITS'(rr_idx);
      end
    end
  end

  assign deq_valid = en && sel_found;
  assign pop       = deq_valid && deq_ready;
  assign deq_data  = head[sel_vc][DATA_W-1:0];
  assign deq_tail  = head[sel_vc][DATA_W];
  assign deq_vc    = sel_vc;

  // Next arbitration pointer, credit and enable state.
  // While the consumer stalls, rr_ptr is parked on the presented VC so a flit
  // landing on a VC earlier in the scan cannot steal the grant mid-stall.
  // While disabled, a pending credit is held rather than lost, and shown once
  // the block is enabled again.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    credit_valid_d = credit_valid_q;
    credit_vc_d    = credit_vc_q;
    en_rx_d        = en;
    if (pop) begin
      rr_ptr_d = (sel_vc == VC_BITS'(NUM_VCS - 1)) ? '0 : sel_vc + 1'b1;
    end else if (deq_valid) begin
      rr_ptr_d = sel_vc;
    end
    if (en) begin
      credit_valid_d = pop;
      credit_vc_d    = pop ? sel_vc : '0;
    end
  end

  // Arbitration, credit and enable registers; reset discards any pending credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      en_rx_q        <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      credit_valid_q <= credit_valid_d;
      credit_vc_q    <= credit_vc_d;
      en_rx_q        <= en_rx_d;
    end
  end

  assign en_receiveFlit = en_rx_q;
  assign sendCredit     = en && credit_valid_q;
  assign credit_out     = (en && credit_valid_q) ? {1'b1, credit_vc_q} : '0;

`ifdef PE_RX_ERR_CHECK_EN
  logic err_q, err_d;
  logic vc_full_hit;

  // Fullness of the VC the incoming flit targets.
  always_comb begin
    vc_full_hit = 1'b0;
    for (int i = 0; i < NUM_VCS; i++) begin
      if (flit_vc == VC_BITS'(i)) begin
        vc_full_hit = full_v[i];
      end
    end
  end

  // Sticky error on overflow or a flit addressed to another port.
  always_comb begin
    err_d = err_q;
    if (en && flit_valid && (vc_full_hit || (flit_dest != recvPortID))) begin
      err_d = 1'b1;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = ^{recvPortID, flit_dest, full_v};
  assign err = 1'b0;
`endif

endmodule
